// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and default constants for the LED sequencer.
//                - state_t : run/stop state encoding
//                - step_t  : {pattern, dwell} step entry at default widths, for
//                            blocks that build step tables for led_seq_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int unsigned C_TICK_DIV_DEFAULT = 50000;  // 1 ms at 50 MHz
    localparam int unsigned C_NUM_LEDS_DEFAULT = 8;
    localparam int unsigned C_DWELL_W_DEFAULT  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [C_NUM_LEDS_DEFAULT-1:0] pattern;
        logic [C_DWELL_W_DEFAULT-1:0]  dwell;
    } step_t;

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Prescaler counting 0..TICK_DIV-1 while enabled. tick_o is
//                high for the one cycle in which the count sits at its
//                terminal value, so a tick occurs every TICK_DIV enabled
//                cycles after a clear.
//  Ports       : clk    - system clock
//                rst    - asynchronous active-low reset
//                clr_i  - synchronous clear of the count (wins over en_i)
//                en_i   - count enable
//                tick_o - one-cycle tick
//  Revision    : 1.0 - initial release
// ============================================================================
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = C_TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned        C_CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(TICK_DIV - 1);

    logic [C_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == C_CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    // Deliberately independent of clr_i: the parent derives its clear from
    // this tick, and feeding it back would form a combinational loop.
    assign tick_o = en_i && (cnt_q == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_ctrl
//  Description : LED pattern sequencer. Steps through a programmable table of
//                {pattern, dwell} entries, holding each pattern for
//                max(dwell,1) ticks of TICK_DIV cycles. Optionally loops.
//  Ports       : clk         - system clock
//                rst         - asynchronous active-low reset
//                cfg_we      - step table write strobe (accepted in any state)
//                cfg_addr    - step table write address
//                cfg_pattern - pattern for the addressed step
//                cfg_dwell   - dwell for the addressed step, in ticks
//                cfg_last    - final step index, captured on accepted start
//                loop_en     - wrap after last step, captured on accepted start
//                start       - request to begin a sequence
//                stop        - request to abort a sequence (wins over start)
//                pins        - registered LED drive
//                busy        - high while running
//                step_idx    - current step index
//                done        - one-cycle pulse when a one-shot run completes
//  Revision    : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = C_NUM_LEDS_DEFAULT,
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned STEP_W    = $clog2(NUM_STEPS),
    parameter int unsigned DWELL_W   = C_DWELL_W_DEFAULT,
    parameter int unsigned TICK_DIV  = C_TICK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [STEP_W-1:0]   cfg_addr,
    input  logic [NUM_LEDS-1:0] cfg_pattern,
    input  logic [DWELL_W-1:0]  cfg_dwell,
    input  logic [STEP_W-1:0]   cfg_last,
    input  logic                loop_en,
    input  logic                start,
    input  logic                stop,
    output logic [NUM_LEDS-1:0] pins,
    output logic                busy,
    output logic [STEP_W-1:0]   step_idx,
    output logic                done
);

    // Table entry at this instance's widths (step_t in the package is fixed
    // at the default widths).
    typedef struct packed {
        logic [NUM_LEDS-1:0] pattern;
        logic [DWELL_W-1:0]  dwell;
    } entry_t;

    localparam logic [STEP_W-1:0] C_STEP0 = '0;

    // A programmed dwell of zero is held for one tick.
    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    entry_t              table_q [NUM_STEPS];
    state_t              state_q;
    logic [NUM_LEDS-1:0] pins_q;
    logic                busy_q;
    logic [STEP_W-1:0]   step_idx_q;
    logic                done_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic [STEP_W-1:0]   last_q;
    logic                loop_q;

    logic                w_tick;
    logic                w_step_end;
    logic                w_at_last;
    logic [STEP_W-1:0]   w_next_idx;
    logic                w_presc_clr;

    // ------------------------------------------------------------------
    // Step table: plain registers, not reset, writable at any time. A
    // write to the running step is only seen when that step is re-entered,
    // because pins is loaded from the table on entry only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            table_q[cfg_addr] <= '{pattern: cfg_pattern, dwell: cfg_dwell};
        end
    end

    // ------------------------------------------------------------------
    // Tick prescaler: runs only in RUN and restarts at every step entry so
    // each step lasts exactly dwell x TICK_DIV cycles.
    // ------------------------------------------------------------------
    // dwell_q never holds 0 in RUN; "<= 1" keeps a corrupted 0 from stalling.
    assign w_step_end  = w_tick && (dwell_q <= DWELL_W'(1));
    assign w_at_last   = (step_idx_q == last_q);
    assign w_next_idx  = w_at_last ? C_STEP0 : step_idx_q + 1'b1;
    assign w_presc_clr = (state_q != RUN) || stop || w_step_end;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (w_presc_clr),
        .en_i   (state_q == RUN),
        .tick_o (w_tick)
    );

    // ------------------------------------------------------------------
    // Run/stop FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pins_q     <= '0;
            busy_q     <= 1'b0;
            step_idx_q <= '0;
            done_q     <= 1'b0;
            dwell_q    <= '0;
            last_q     <= '0;
            loop_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // stop in the same cycle cancels the start.
                    if (start && !stop) begin
                        last_q     <= cfg_last;
                        loop_q     <= loop_en;
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        pins_q     <= table_q[C_STEP0].pattern;
                        step_idx_q <= C_STEP0;
                        dwell_q    <= eff_dwell(table_q[C_STEP0].dwell);
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        pins_q     <= '0;
                        step_idx_q <= '0;
                        dwell_q    <= '0;
                    end else if (w_step_end) begin
                        if (w_at_last && !loop_q) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            pins_q     <= '0;
                            step_idx_q <= '0;
                            dwell_q    <= '0;
                            done_q     <= 1'b1;
                        end else begin
                            pins_q     <= table_q[w_next_idx].pattern;
                            step_idx_q <= w_next_idx;
                            dwell_q    <= eff_dwell(table_q[w_next_idx].dwell);
                        end
                    end else if (w_tick) begin
                        dwell_q <= dwell_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    pins_q  <= '0;
                end
            endcase
        end
    end

    assign pins     = pins_q;
    assign busy     = busy_q;
    assign step_idx = step_idx_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_seq_ctrl
//  Description : Self-checking bench for led_seq_ctrl. Stimulus pushes the
//                expected sequence of output segments (a stable
//                {pins, busy, step_idx, done} value and its length in cycles);
//                the monitor closes a segment whenever the outputs change and
//                compares it against the head of the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;
    import led_pkg::*;

    localparam int unsigned C_TICK_DIV = 4;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_pattern;
    logic [7:0] cfg_dwell;
    logic [2:0] cfg_last;
    logic       loop_en;
    logic       start;
    logic       stop;
    logic [7:0] pins;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    led_seq_ctrl #(
        .NUM_LEDS  (8),
        .NUM_STEPS (8),
        .DWELL_W   (8),
        .TICK_DIV  (C_TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_pattern (cfg_pattern),
        .cfg_dwell   (cfg_dwell),
        .cfg_last    (cfg_last),
        .loop_en     (loop_en),
        .start       (start),
        .stop        (stop),
        .pins        (pins),
        .busy        (busy),
        .step_idx    (step_idx),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pins;
        logic       busy;
        logic [2:0] idx;
        logic       done;
    } key_t;

    typedef struct {
        key_t key;
        int   len;
        bit   exact;   // 1: length must match, 0: length is a minimum
    } seg_t;

    seg_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    key_t mon_cur;
    key_t seg_key;
    int   seg_len = 0;
    bit   seg_valid = 1'b0;
    int   seg_num = 0;

    function automatic key_t mk(input logic [7:0] p, input logic b,
                                input logic [2:0] i, input logic d);
        key_t r;
        r.pins = p;
        r.busy = b;
        r.idx  = i;
        r.done = d;
        return r;
    endfunction

    task automatic push(input key_t kk, input int len, input bit exact);
        seg_t s;
        s.key   = kk;
        s.len   = len;
        s.exact = exact;
        exp_q.push_back(s);
    endtask

    task automatic push_run(input logic [7:0] p, input logic [2:0] i, input int len);
        push(mk(p, 1'b1, i, 1'b0), len, 1'b1);
    endtask

    task automatic push_idle(input int min_len);
        push(mk(8'h00, 1'b0, 3'd0, 1'b0), min_len, 1'b0);
    endtask

    task automatic close_seg(input key_t got, input int glen);
        seg_t e;
        checks++;
        seg_num++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL seg%0d unexpected: got pins=%h busy=%b idx=%0d done=%b len=%0d, required no segment",
                     seg_num, got.pins, got.busy, got.idx, got.done, glen);
        end else begin
            e = exp_q.pop_front();
            if (got != e.key || (e.exact ? (glen != e.len) : (glen < e.len))) begin
                errors++;
                $display("FAIL seg%0d: got pins=%h busy=%b idx=%0d done=%b len=%0d, required pins=%h busy=%b idx=%0d done=%b len%s%0d",
                         seg_num, got.pins, got.busy, got.idx, got.done, glen,
                         e.key.pins, e.key.busy, e.key.idx, e.key.done,
                         e.exact ? "=" : ">=", e.len);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Monitor: segments outputs into runs of constant value.
    always @(negedge clk) begin
        mon_cur = mk(pins, busy, step_idx, done);
        if (mon_en) begin
            if (!seg_valid) begin
                seg_key   = mon_cur;
                seg_len   = 1;
                seg_valid = 1'b1;
            end else if (mon_cur == seg_key) begin
                seg_len++;
            end else begin
                close_seg(seg_key, seg_len);
                seg_key = mon_cur;
                seg_len = 1;
            end
        end else if (seg_valid) begin
            close_seg(seg_key, seg_len);
            seg_valid = 1'b0;
        end
    end

    task automatic write_step(input logic [2:0] a, input logic [7:0] p, input logic [7:0] d);
        @(negedge clk);
        cfg_we      = 1'b1;
        cfg_addr    = a;
        cfg_pattern = p;
        cfg_dwell   = d;
        @(negedge clk);
        cfg_we      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_dwell = '0;
        cfg_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        #1 rst = 1'b0;

        // ---- Reset then idle ----
        repeat (3) @(negedge clk);
        check("reset_pins", 32'(pins), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_idx",  32'(step_idx), 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;
        push_idle(100);
        repeat (100) @(negedge clk);

        // ---- One-shot run, then a restart on the done cycle ----
        write_step(3'd0, 8'h01, 8'd2);
        write_step(3'd1, 8'h02, 8'd1);
        write_step(3'd2, 8'h04, 8'd3);
        cfg_last = 3'd2;
        loop_en  = 1'b0;
        for (int r = 0; r < 2; r++) begin
            push_run(8'h01, 3'd0, 2 * C_TICK_DIV);
            push_run(8'h02, 3'd1, 1 * C_TICK_DIV);
            push_run(8'h04, 3'd2, 3 * C_TICK_DIV);
            push(mk(8'h00, 1'b0, 3'd0, 1'b1), 1, 1'b1);
        end
        push_idle(1);
        @(negedge clk); start = 1'b1;          // sample 0
        @(negedge clk); start = 1'b0;          // sample 1
        repeat (24) @(negedge clk);            // sample 25: done visible
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);

        // ---- Loop with zero dwell, stop during step 1, start+stop collision ----
        write_step(3'd0, 8'hAA, 8'd0);
        write_step(3'd1, 8'h55, 8'd1);
        cfg_last = 3'd1;
        loop_en  = 1'b1;
        for (int l = 0; l < 3; l++) begin
            push_run(8'hAA, 3'd0, C_TICK_DIV);
            push_run(8'h55, 3'd1, C_TICK_DIV);
        end
        push_run(8'hAA, 3'd0, C_TICK_DIV);
        push_run(8'h55, 3'd1, 2);
        push_idle(1);
        @(negedge clk); start = 1'b1;          // sample 0
        @(negedge clk); start = 1'b0;          // sample 1
        repeat (29) @(negedge clk);            // sample 30, second cycle of 55
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);

        // ---- Live reconfiguration and ignored start mid-run ----
        write_step(3'd0, 8'h11, 8'd1);
        write_step(3'd1, 8'h22, 8'd1);
        cfg_last = 3'd1;
        loop_en  = 1'b1;
        push_run(8'h11, 3'd0, C_TICK_DIV);
        push_run(8'h22, 3'd1, C_TICK_DIV);
        push_run(8'hF0, 3'd0, C_TICK_DIV);
        push_run(8'h22, 3'd1, C_TICK_DIV);
        push_idle(1);
        @(negedge clk); start = 1'b1;          // sample 0
        @(negedge clk); start = 1'b0;          // sample 1
        @(negedge clk);                        // sample 2, inside step 0
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_pattern = 8'hF0; cfg_dwell = 8'd1;
        @(negedge clk); cfg_we = 1'b0;         // sample 3
        repeat (3) @(negedge clk);             // sample 6, inside step 1
        start = 1'b1;
        @(negedge clk); start = 1'b0;          // sample 7
        repeat (9) @(negedge clk);             // sample 16, last cycle of 22
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        repeat (5) @(negedge clk);

        // ---- Asynchronous reset during step 2 ----
        write_step(3'd0, 8'h01, 8'd2);
        write_step(3'd1, 8'h02, 8'd1);
        write_step(3'd2, 8'h04, 8'd3);
        cfg_last = 3'd2;
        loop_en  = 1'b0;
        push_run(8'h01, 3'd0, 2 * C_TICK_DIV);
        push_run(8'h02, 3'd1, 1 * C_TICK_DIV);
        push_run(8'h04, 3'd2, 4);
        push_idle(1);
        @(negedge clk); start = 1'b1;          // sample 0
        @(negedge clk); start = 1'b0;          // sample 1
        repeat (15) @(negedge clk);            // sample 16, 4th cycle of step 2
        #2 rst = 1'b0;
        #1;
        check("async_rst_pins", 32'(pins), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_idx",  32'(step_idx), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (10) @(negedge clk);

        // ---- Flush the monitor and make sure nothing is left over ----
        mon_en = 1'b0;
        repeat (2) @(negedge clk);
        check("expected_queue_left", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
